// File: rtl/mac_acc_accumulator_block_pkg.sv
// Shared constants and helpers for the MAC accumulator stage.
package mac_acc_accumulator_block_pkg;

    localparam int MAC_CONF_WIDTH = 4;
    localparam int MAC_MIN_WIDTH  = 8;
    localparam int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH;
    localparam int MAC_ACC_WIDTH  = 2 * MAC_MULT_WIDTH;

    // Field positions inside cfg
    localparam int CFG_SIGNED  = 3;
    localparam int CFG_MAC     = 2;
    localparam int CFG_MODE_HI = 1;
    localparam int CFG_MODE_LO = 0;

    // Lane configuration; 2'b11 behaves as Single
    typedef enum logic [1:0] {
        MODE_SINGLE     = 2'b00,
        MODE_DUAL       = 2'b01,
        MODE_QUAD       = 2'b10,
        MODE_SINGLE_ALT = 2'b11
    } mode_e;

    // Configuration assumed after reset: Single, unsigned, mac
    localparam logic [MAC_CONF_WIDTH-1:0] CFG_RESET = 4'b0100;

    // Segments that sit at the top of a lane and therefore own an ovf bit
    function automatic logic [3:0] lane_top_mask(input logic [1:0] mode);
        case (mode)
            MODE_DUAL: lane_top_mask = 4'b1010;
            MODE_QUAD: lane_top_mask = 4'b1000;
            default:   lane_top_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mac_acc_accumulator_block_segment.sv
// One accumulator segment adder: sum, carry-out and signed overflow.
module mac_acc_segment
    import mac_acc_accumulator_block_pkg::*;
(
    input  logic [MAC_ACC_WIDTH-1:0] a,
    input  logic [MAC_ACC_WIDTH-1:0] b,
    input  logic                     cin,
    output logic [MAC_ACC_WIDTH-1:0] sum,
    output logic                     cout,
    output logic                     sovf
);

    logic [MAC_ACC_WIDTH:0] full_sum;

    // Widen by one bit so the carry-out falls out of the add
    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b} + {{MAC_ACC_WIDTH{1'b0}}, cin};
        sum      = full_sum[MAC_ACC_WIDTH-1:0];
        cout     = full_sum[MAC_ACC_WIDTH];
        // Two's-complement overflow: like-signed operands, different-signed result
        sovf     = (a[MAC_ACC_WIDTH-1] == b[MAC_ACC_WIDTH-1]) &&
                   (sum[MAC_ACC_WIDTH-1] != a[MAC_ACC_WIDTH-1]);
    end

endmodule

// File: rtl/mac_acc_accumulator_block.sv
// Four-segment accumulator with configurable carry chaining,
// sticky per-lane overflow, synchronous clear and 1-cycle valid.
module mac_acc_accumulator_block
    import mac_acc_accumulator_block_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [MAC_CONF_WIDTH-1:0] cfg,
    input  logic                      in_valid,
    input  logic                      acc_clr,
    input  logic [MAC_ACC_WIDTH-1:0]  C0_in,
    input  logic [MAC_ACC_WIDTH-1:0]  C1_in,
    input  logic [MAC_ACC_WIDTH-1:0]  C2_in,
    input  logic [MAC_ACC_WIDTH-1:0]  C3_in,
    output logic [MAC_ACC_WIDTH-1:0]  acc0_out,
    output logic [MAC_ACC_WIDTH-1:0]  acc1_out,
    output logic [MAC_ACC_WIDTH-1:0]  acc2_out,
    output logic [MAC_ACC_WIDTH-1:0]  acc3_out,
    output logic [3:0]                ovf,
    output logic                      out_valid
);

    // Only the sign and lane-mode fields decide whether a new run starts,
    // so only those are remembered between beats.
    localparam logic [2:0] CFG_Q_RESET = {CFG_RESET[CFG_SIGNED], CFG_RESET[CFG_MODE_HI:CFG_MODE_LO]};

    logic [MAC_ACC_WIDTH-1:0] c_seg [4];
    logic [MAC_ACC_WIDTH-1:0] sum_seg [4];
    logic [MAC_ACC_WIDTH-1:0] acc_q [4];
    logic [MAC_ACC_WIDTH-1:0] acc_d [4];
    logic [3:0]               cin_seg;
    logic [3:0]               cout_seg;
    logic [3:0]               sovf_seg;
    logic [3:0]               ovf_q, ovf_d;
    logic [2:0]               cfg_q, cfg_d;
    logic                     first_beat_q, first_beat_d;
    logic                     out_valid_q, out_valid_d;

    logic [1:0] mode;
    logic       accept;
    logic       mode_chg;
    logic       do_load;
    logic [3:0] top_mask;
    logic [3:0] ovf_new;

    assign c_seg[0] = C0_in;
    assign c_seg[1] = C1_in;
    assign c_seg[2] = C2_in;
    assign c_seg[3] = C3_in;

    // Beat acceptance, load decision and lane shape for the incoming cfg
    always_comb begin
        mode     = cfg[CFG_MODE_HI:CFG_MODE_LO];
        accept   = en & in_valid;
        mode_chg = (cfg[CFG_SIGNED] != cfg_q[2]) || (mode != cfg_q[1:0]);
        do_load  = ~cfg[CFG_MAC] | acc_clr | first_beat_q | mode_chg;
        top_mask = lane_top_mask(mode);
        ovf_new  = cfg[CFG_SIGNED] ? sovf_seg : cout_seg;
    end

    // Carry chain between segments follows the lane configuration
    always_comb begin
        cin_seg    = 4'b0000;
        cin_seg[1] = (mode == MODE_DUAL || mode == MODE_QUAD) ? cout_seg[0] : 1'b0;
        cin_seg[2] = (mode == MODE_QUAD) ? cout_seg[1] : 1'b0;
        cin_seg[3] = (mode == MODE_DUAL || mode == MODE_QUAD) ? cout_seg[2] : 1'b0;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_seg
            mac_acc_segment u_seg (
                .a    (acc_q[gi]),
                .b    (c_seg[gi]),
                .cin  (cin_seg[gi]),
                .sum  (sum_seg[gi]),
                .cout (cout_seg[gi]),
                .sovf (sovf_seg[gi])
            );
        end
    endgenerate

    // Next-state: load/accumulate on a beat, clear without a beat, hold when idle
    always_comb begin
        for (int i = 0; i < 4; i++) acc_d[i] = acc_q[i];
        ovf_d        = ovf_q;
        cfg_d        = cfg_q;
        first_beat_d = first_beat_q;
        out_valid_d  = 1'b0;
        if (en) begin
            out_valid_d = accept;
            if (accept) begin
                cfg_d        = {cfg[CFG_SIGNED], mode};
                first_beat_d = 1'b0;
                if (do_load) begin
                    for (int i = 0; i < 4; i++) acc_d[i] = c_seg[i];
                    ovf_d = 4'b0000;
                end else begin
                    for (int i = 0; i < 4; i++) acc_d[i] = sum_seg[i];
                    ovf_d = (ovf_q | ovf_new) & top_mask;
                end
            end else if (acc_clr) begin
                for (int i = 0; i < 4; i++) acc_d[i] = '0;
                ovf_d        = 4'b0000;
                first_beat_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
            ovf_q        <= 4'b0000;
            cfg_q        <= CFG_Q_RESET;
            first_beat_q <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
            ovf_q        <= ovf_d;
            cfg_q        <= cfg_d;
            first_beat_q <= first_beat_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign acc0_out  = acc_q[0];
    assign acc1_out  = acc_q[1];
    assign acc2_out  = acc_q[2];
    assign acc3_out  = acc_q[3];
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_acc_accumulator_block.sv
// Directed self-checking bench for mac_acc_accumulator_block.
module tb_mac_acc_accumulator_block;

    logic        clk = 1'b0;
    logic        rst, en, in_valid, acc_clr;
    logic [3:0]  cfg;
    logic [31:0] c0, c1, c2, c3;
    logic [31:0] acc0, acc1, acc2, acc3;
    logic [3:0]  ovf;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_acc_accumulator_block dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg       (cfg),
        .in_valid  (in_valid),
        .acc_clr   (acc_clr),
        .C0_in     (c0),
        .C1_in     (c1),
        .C2_in     (c2),
        .C3_in     (c3),
        .acc0_out  (acc0),
        .acc1_out  (acc1),
        .acc2_out  (acc2),
        .acc3_out  (acc3),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge
    task automatic step(input logic r, input logic e, input logic v, input logic clr,
                        input logic [3:0] cf, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] a3);
        rst = r; en = e; in_valid = v; acc_clr = clr; cfg = cf;
        c0 = a0; c1 = a1; c2 = a2; c3 = a3;
        @(posedge clk);
        #1;
        $display("step rst=%0b en=%0b v=%0b clr=%0b cfg=%b C=%h_%h_%h_%h -> acc=%h_%h_%h_%h ovf=%b ov=%0b",
                 r, e, v, clr, cf, a3, a2, a1, a0, acc3, acc2, acc1, acc0, ovf, out_valid);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; cfg = 4'b0100;
        c0 = '0; c1 = '0; c2 = '0; c3 = '0;

        // Reset state
        step(1, 0, 0, 0, 4'b0100, 0, 0, 0, 0);
        chk("rst_acc0", acc0, 0);
        chk("rst_acc3", acc3, 0);
        chk("rst_ovf", {28'd0, ovf}, 0);
        chk("rst_ov", {31'd0, out_valid}, 0);

        // Single unsigned mac: 5 then 7
        step(0, 1, 1, 0, 4'b0100, 5, 0, 0, 0);
        chk("s_load_acc0", acc0, 5);
        chk("s_load_ov", {31'd0, out_valid}, 1);
        step(0, 1, 1, 0, 4'b0100, 7, 0, 0, 0);
        chk("s_acc_acc0", acc0, 12);
        chk("s_acc_acc1", acc1, 0);
        chk("s_acc_acc2", acc2, 0);
        chk("s_acc_ovf", {28'd0, ovf}, 0);
        // Idle cycle: valid drops, value holds
        step(0, 1, 0, 0, 4'b0100, 99, 0, 0, 0);
        chk("idle_ov", {31'd0, out_valid}, 0);
        chk("idle_acc0", acc0, 12);
        // Single lane 2 unsigned wrap: no carry into segment 3
        step(0, 1, 1, 0, 4'b0100, 0, 0, 32'hFFFF_FFFF, 0);
        step(0, 1, 1, 0, 4'b0100, 0, 0, 1, 0);
        chk("s_wrap_acc2", acc2, 0);
        chk("s_wrap_acc3", acc3, 0);
        chk("s_wrap_ovf", {28'd0, ovf}, 32'h4);

        // Dual unsigned: mode change loads, then carry into segment 1
        step(0, 1, 1, 0, 4'b0101, 32'hFFFF_FFFF, 0, 0, 0);
        chk("d_load_acc0", acc0, 32'hFFFF_FFFF);
        chk("d_load_ovf", {28'd0, ovf}, 0);
        step(0, 1, 1, 0, 4'b0101, 1, 0, 0, 0);
        chk("d_acc0", acc0, 0);
        chk("d_acc1", acc1, 1);
        chk("d_ovf", {28'd0, ovf}, 0);

        // Quad signed: full carry ripple to segment 3 and signed overflow
        step(0, 1, 1, 0, 4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
        chk("q_load_acc3", acc3, 32'h7FFF_FFFF);
        step(0, 1, 1, 0, 4'b1110, 1, 0, 0, 0);
        chk("q_acc3", acc3, 32'h8000_0000);
        chk("q_acc2", acc2, 0);
        chk("q_acc1", acc1, 0);
        chk("q_acc0", acc0, 0);
        chk("q_ovf", {28'd0, ovf}, 32'h8);
        step(0, 1, 1, 0, 4'b1110, 0, 0, 0, 0);
        chk("q_sticky_ovf", {28'd0, ovf}, 32'h8);
        chk("q_sticky_acc3", acc3, 32'h8000_0000);

        // Mul mode: every beat loads
        step(0, 1, 1, 0, 4'b0000, 3, 0, 0, 0);
        chk("m_acc0_a", acc0, 3);
        chk("m_acc3_a", acc3, 0);
        chk("m_ovf", {28'd0, ovf}, 0);
        step(0, 1, 1, 0, 4'b0000, 9, 0, 0, 0);
        chk("m_acc0_b", acc0, 9);

        // Build ovf in Single lane 0, then clear-with-beat
        step(0, 1, 1, 1, 4'b0100, 32'hFFFF_FFFF, 0, 0, 0);
        chk("c_load_acc0", acc0, 32'hFFFF_FFFF);
        step(0, 1, 1, 0, 4'b0100, 1, 0, 0, 0);
        chk("c_wrap_ovf", {28'd0, ovf}, 32'h1);
        step(0, 1, 1, 0, 4'b0100, 100, 0, 0, 0);
        chk("c_acc0_100", acc0, 100);
        chk("c_ovf_sticky", {28'd0, ovf}, 32'h1);
        step(0, 1, 1, 1, 4'b0100, 4, 0, 0, 0);
        chk("clr_beat_acc0", acc0, 4);
        chk("clr_beat_ovf", {28'd0, ovf}, 0);
        // Mode change Single -> Dual loads
        step(0, 1, 1, 0, 4'b0101, 2, 0, 0, 0);
        chk("chg_acc0", acc0, 2);
        chk("chg_acc1", acc1, 0);

        // Clear without a beat
        step(0, 1, 0, 1, 4'b0101, 77, 0, 0, 0);
        chk("clr_only_acc0", acc0, 0);
        chk("clr_only_ov", {31'd0, out_valid}, 0);
        step(0, 1, 1, 0, 4'b0101, 5, 0, 0, 0);
        chk("post_clr_load", acc0, 5);
        step(0, 1, 1, 0, 4'b0101, 6, 0, 0, 0);
        chk("post_clr_acc", acc0, 11);

        // en=0 holds everything, including acc_clr ignored
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, (k == 1), 4'b0110, 50, 50, 50, 50);
            chk("en0_acc0", acc0, 11);
            chk("en0_ov", {31'd0, out_valid}, 0);
        end
        step(0, 1, 1, 0, 4'b0101, 1, 0, 0, 0);
        chk("en_resume_acc0", acc0, 12);

        // Reset mid-accumulation overrides a valid beat
        step(1, 1, 1, 0, 4'b0101, 40, 40, 40, 40);
        chk("rst2_acc0", acc0, 0);
        chk("rst2_acc1", acc1, 0);
        chk("rst2_ovf", {28'd0, ovf}, 0);
        chk("rst2_ov", {31'd0, out_valid}, 0);
        step(0, 1, 1, 0, 4'b0100, 7, 0, 0, 0);
        chk("rst2_first_load", acc0, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_acc_accumulator_block.md
Name: mac_acc_accumulator_block

Overview:
Accumulation stage directly downstream of the product negator. It receives the four sign-corrected 32-bit product segments C0..C3 and adds them into four registered accumulator segments. The carry chain between segments follows the Single/Dual/Quad configuration. The block provides per-lane sticky overflow flags, a synchronous clear, and a one-cycle valid pipeline to the MAC output.

Parameters:
MAC_CONF_WIDTH, 4, config width; bit3 signed(1)/unsigned(0), bit2 mac(1)/mul(0), bits[1:0] 00/11=Single, 01=Dual, 10=Quad
MAC_MIN_WIDTH, 8, base operand width
MAC_MULT_WIDTH, 2*MAC_MIN_WIDTH, product width
MAC_ACC_WIDTH, 2*MAC_MULT_WIDTH, width of one accumulator segment

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  stage enable; when 0 no beat is accepted and all state holds
cfg  in  MAC_CONF_WIDTH  configuration, sampled on each accepted beat
in_valid  in  1  C0_in..C3_in carry a valid product this cycle
acc_clr  in  1  zero the accumulators and overflow flags
C0_in..C3_in  in  MAC_ACC_WIDTH each  sign-corrected product segments, C0 least significant
acc0_out..acc3_out  out  MAC_ACC_WIDTH each  registered accumulator segments
ovf  out  4  sticky overflow flag per segment; only lane-top bits are meaningful
out_valid  out  1  acc*_out updated by a beat in the previous cycle

Behaviour:
- Reset (rst=1 at an edge): acc0..acc3=0, ovf=0, out_valid=0, latched cfg=Single unsigned mac (4'b0100), first_beat=1. Reset overrides every other input, including mid-accumulation.
- Acceptance: a beat is accepted when en & in_valid. Latency is 1 cycle: out_valid <= en & in_valid.
- Lane structure:
  - Single: four independent 32-bit lanes.
  - Dual: {acc1,acc0} and {acc3,acc2} are 64-bit lanes.
  - Quad: {acc3..acc0} is one 128-bit lane.
  - Carry into segment 1 = cout0 unless Single. Carry into segment 2 = cout1 only in Quad. Carry into segment 3 = cout2 unless Single. All other carry-ins are 0.
- Lane tops (the only segments that update ovf): Single = 0,1,2,3; Dual = 1,3; Quad = 3. Non-top ovf bits are forced to 0.
- Per-segment next value on an accepted beat:
  - Load, when any of: mul mode (cfg[2]=0), acc_clr=1, or first_beat=1. acc_i <= C_i_in.
  - Otherwise accumulate: acc_i <= acc_i + C_i_in + carry_in_i (mod 2^MAC_ACC_WIDTH).
- Overflow, evaluated on accumulate beats at lane tops only:
  - Signed (cfg[3]=1): operand MSBs equal and result MSB differs.
  - Unsigned: segment carry-out = 1.
  - ovf is OR-ed in (sticky). A load beat sets ovf to 0 for that lane.
- first_beat is set by reset, by acc_clr, and by an accepted beat whose cfg[3] or cfg[1:0] differ from the latched cfg. An accepted beat with a mode change therefore loads rather than accumulates. first_beat is cleared by any accepted beat that loads. The latched cfg updates on every accepted beat.
- acc_clr without an accepted beat (takes effect only when en=1): acc=0, ovf=0, out_valid=0.
- acc_clr together with an accepted beat: treated as a load (clear, then add the product), ovf=0.
- en=0: acc, ovf, latched cfg and first_beat hold; out_valid <= 0; in_valid and acc_clr are ignored.
- Wrap-around: results are truncated modulo the lane width. No saturation.

Decomposition:
- mac_const.vh gains:
  - cfg field index defines: CFG_SIGNED=3, CFG_MAC=2, CFG_MODE_HI=1, CFG_MODE_LO=0
  - mode encodings: MODE_SINGLE=2'b00, MODE_DUAL=2'b01, MODE_QUAD=2'b10
  - reset cfg value 4'b0100
- One sub-module, mac_acc_segment: a MAC_ACC_WIDTH adder with cin, cout and a signed-overflow output, instantiated four times. The top level holds the carry muxing, load/accumulate select, registers, ovf and first_beat logic.

Test Plan:
- Single unsigned mac; beats with C0=5 then C0=7; C1..C3=0 → acc0=12 on the second out_valid; acc1..3=0; ovf=0.
- Dual unsigned; load C1:C0=0x00000000_FFFFFFFF, then add C1:C0=0x00000000_00000001 → acc1=1, acc0=0; ovf[1]=0.
- Quad signed; load C3..C0 = 0x7FFFFFFF,FFFFFFFF,FFFFFFFF,FFFFFFFF, then add C0=1 with C1..C3=0 → acc3=0x80000000, acc2..acc0=0; ovf=4'b1000; ovf stays 1 after a further add of 0.
- Mul mode (cfg=4'b0000); C0=3 then C0=9 → acc0=3 then 9, never 12.
- acc_clr together with in_valid while acc0=100, C0=4 → acc0=4; ovf cleared. A following beat with a cfg change from Single to Dual and C0=2 → acc0=2 (load, not accumulate).
- en=0 for 3 cycles with in_valid=1 → acc unchanged, out_valid=0. Asserting rst during accumulation → all outputs 0 next cycle.
